// File: rtl/gradient_compute_pipe.sv
// 3-stage Ix/Iy/It gradient pipeline over averaged curr/prev frames.
// Macro GRADCOMP_SAT_EN: saturate results to GRAD_WIDTH instead of wrapping.
module gradient_compute_pipe #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIXEL_WIDTH = 8,
  parameter int GRAD_WIDTH  = 12,
  localparam int X_W = $clog2(WIDTH),
  localparam int Y_W = $clog2(HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   cfg_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [PIXEL_WIDTH-1:0]       pixel_curr,
  input  logic [PIXEL_WIDTH-1:0]       pixel_prev,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [GRAD_WIDTH-1:0] grad_x,
  output logic signed [GRAD_WIDTH-1:0] grad_y,
  output logic signed [GRAD_WIDTH-1:0] grad_t,
  output logic [X_W-1:0]               out_x,
  output logic [Y_W-1:0]               out_y
);

  localparam int P   = PIXEL_WIDTH;
  localparam int S_W = P + 6;
  localparam int E_W = ((S_W > GRAD_WIDTH) ? S_W : GRAD_WIDTH) + 1;
`ifdef GRADCOMP_SAT_EN
  localparam logic signed [E_W-1:0] G_MAX =
    E_W'((1 << (GRAD_WIDTH - 1)) - 1);
  localparam logic signed [E_W-1:0] G_MIN = -G_MAX - 1;
`endif

  typedef logic [P-1:0] pix_t;

  logic           stall, acc, emit, is00;
  logic [X_W-1:0] x, px;
  logic [Y_W-1:0] y, py;
  logic [1:0]     frame_mode, eff_mode;

  pix_t lc1 [WIDTH];
  pix_t lc2 [WIDTH];
  pix_t lp1 [WIDTH];
  pix_t lp2 [WIDTH];
  pix_t wc [3][3];
  pix_t wp [3][3];

  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign acc = in_valid & in_ready;
  assign px = in_sof ? '0 : x;
  assign py = in_sof ? '0 : y;
  assign is00 = (px == '0) && (py == '0);
  assign eff_mode = !is00 ? frame_mode :
                    (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
  assign emit = acc && (px >= X_W'(2)) && (py >= Y_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      frame_mode <= '0;
    end else if (acc) begin
      frame_mode <= eff_mode;
      if (px == X_W'(WIDTH - 1)) begin
        x <= '0;
        y <= (py == Y_W'(HEIGHT - 1)) ? '0 : py + Y_W'(1);
      end else begin
        x <= px + X_W'(1);
        y <= py;
      end
    end
  end

  // Line RAMs and window are not reset; emission never reads stale rows.
  always_ff @(posedge clk) begin
    if (acc) begin
      lc1[px] <= pixel_curr;
      lc2[px] <= lc1[px];
      lp1[px] <= pixel_prev;
      lp2[px] <= lp1[px];
      for (int r = 0; r < 3; r++) begin
        wc[r][0] <= wc[r][1];
        wc[r][1] <= wc[r][2];
        wp[r][0] <= wp[r][1];
        wp[r][1] <= wp[r][2];
      end
      wc[0][2] <= lc2[px];
      wc[1][2] <= lc1[px];
      wc[2][2] <= pixel_curr;
      wp[0][2] <= lp2[px];
      wp[1][2] <= lp1[px];
      wp[2][2] <= pixel_prev;
    end
  end

  // S1: window capture qualifier and centre coordinates
  logic           s1_v;
  logic [X_W-1:0] s1_x;
  logic [Y_W-1:0] s1_y;
  logic [1:0]     s1_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
      s1_m <= '0;
    end else if (!stall) begin
      s1_v <= emit;
      if (emit) begin
        s1_x <= px - X_W'(1);
        s1_y <= py - Y_W'(1);
        s1_m <= eff_mode;
      end
    end
  end

  // S2: average and row/column differences
  pix_t               avg [3][3];
  logic signed [P:0]  dx [3];
  logic signed [P:0]  dy [3];
  logic signed [P:0]  dt;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        avg[r][c] = P'(({1'b0, wc[r][c]} + {1'b0, wp[r][c]}) >> 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      dx[i] = $signed({1'b0, avg[i][2]}) - $signed({1'b0, avg[i][0]});
      dy[i] = $signed({1'b0, avg[2][i]}) - $signed({1'b0, avg[0][i]});
    end
    dt = $signed({1'b0, wp[1][1]}) - $signed({1'b0, wc[1][1]});
  end

  logic                  s2_v;
  logic [X_W-1:0]        s2_x;
  logic [Y_W-1:0]        s2_y;
  logic [1:0]            s2_m;
  logic signed [S_W-1:0] s2_ox, s2_mx, s2_oy, s2_my;
  logic signed [P:0]     s2_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_x  <= '0;
      s2_y  <= '0;
      s2_m  <= '0;
      s2_ox <= '0;
      s2_mx <= '0;
      s2_oy <= '0;
      s2_my <= '0;
      s2_t  <= '0;
    end else if (!stall) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_x  <= s1_x;
        s2_y  <= s1_y;
        s2_m  <= s1_m;
        s2_ox <= S_W'(dx[0]) + S_W'(dx[2]);
        s2_mx <= S_W'(dx[1]);
        s2_oy <= S_W'(dy[0]) + S_W'(dy[2]);
        s2_my <= S_W'(dy[1]);
        s2_t  <= dt;
      end
    end
  end

  // S3: kernel weighting, arithmetic shift, narrowing
  function automatic logic signed [GRAD_WIDTH-1:0] narrow(
    input logic signed [S_W-1:0] v
  );
    logic signed [E_W-1:0] e;
    e = E_W'(v);
`ifdef GRADCOMP_SAT_EN
    if (e > G_MAX) e = G_MAX;
    else if (e < G_MIN) e = G_MIN;
`endif
    return e[GRAD_WIDTH-1:0];
  endfunction

  logic signed [S_W-1:0] rx, ry;

  always_comb begin
    rx = '0;
    ry = '0;
    case (s2_m)
      2'd1: begin
        rx = s2_mx >>> 1;
        ry = s2_my >>> 1;
      end
      2'd2: begin
        rx = ((s2_ox <<< 1) + s2_ox + (s2_mx <<< 3) + (s2_mx <<< 1)) >>> 5;
        ry = ((s2_oy <<< 1) + s2_oy + (s2_my <<< 3) + (s2_my <<< 1)) >>> 5;
      end
      default: begin
        rx = (s2_ox + (s2_mx <<< 1)) >>> 3;
        ry = (s2_oy + (s2_my <<< 1)) >>> 3;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      grad_x    <= '0;
      grad_y    <= '0;
      grad_t    <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (!stall) begin
      out_valid <= s2_v;
      if (s2_v) begin
        grad_x <= narrow(rx);
        grad_y <= narrow(ry);
        grad_t <= narrow(S_W'(s2_t));
        out_x  <= s2_x;
        out_y  <= s2_y;
      end
    end
  end

endmodule

// File: tb/tb_gradient_compute_pipe.sv
// Scoreboard bench: random/directed 5x5 frames vs. a kernel-level model.
module tb_gradient_compute_pipe;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PW = 8;
  localparam int GW = 8;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic                 clk = 0;
  logic                 rst_n = 0;
  logic [1:0]           cfg_mode = 0;
  logic                 in_valid = 0;
  logic                 in_ready;
  logic                 in_sof = 0;
  logic [PW-1:0]        pixel_curr = 0;
  logic [PW-1:0]        pixel_prev = 0;
  logic                 out_valid;
  logic                 out_ready = 1;
  logic signed [GW-1:0] grad_x, grad_y, grad_t;
  logic [XW-1:0]        out_x;
  logic [YW-1:0]        out_y;

  gradient_compute_pipe #(
    .WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW), .GRAD_WIDTH(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .pixel_curr(pixel_curr), .pixel_prev(pixel_prev),
    .out_valid(out_valid), .out_ready(out_ready),
    .grad_x(grad_x), .grad_y(grad_y), .grad_t(grad_t),
    .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int gx; int gy; int gt; } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail = 0;
  int fc [H][W];
  int fp [H][W];
  bit bp_en = 0;
  int stall_cnt = 0;

  task automatic check(string name, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int narrow(int v);
    int t;
`ifdef GRADCOMP_SAT_EN
    if (v > (1 << (GW - 1)) - 1) return (1 << (GW - 1)) - 1;
    if (v < -(1 << (GW - 1))) return -(1 << (GW - 1));
    return v;
`else
    t = v & ((1 << GW) - 1);
    if (t >= (1 << (GW - 1))) t -= (1 << GW);
    return t;
`endif
  endfunction

  // Kernel expressed directly as weights on averaged 3x3 neighbourhood
  function automatic exp_t model(int cx, int cy, int mode);
    exp_t e;
    int a [3][3];
    int w0, w1, sh, sx, sy;
    case (mode)
      1: begin w0 = 0; w1 = 1;  sh = 1; end
      2: begin w0 = 3; w1 = 10; sh = 5; end
      default: begin w0 = 1; w1 = 2; sh = 3; end
    endcase
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        a[r][c] = (fc[cy-1+r][cx-1+c] + fp[cy-1+r][cx-1+c]) / 2;
    sx = w0 * (a[0][2] - a[0][0]) + w1 * (a[1][2] - a[1][0])
       + w0 * (a[2][2] - a[2][0]);
    sy = w0 * (a[2][0] - a[0][0]) + w1 * (a[2][1] - a[0][1])
       + w0 * (a[2][2] - a[0][2]);
    e.x = cx;
    e.y = cy;
    e.gx = narrow(sx >>> sh);
    e.gy = narrow(sy >>> sh);
    e.gt = narrow(fp[cy][cx] - fc[cy][cx]);
    return e;
  endfunction

  task automatic send(int c, int p, bit sof);
    bit done = 0;
    int waited = 0;
    pixel_curr = PW'(c);
    pixel_prev = PW'(p);
    in_sof = sof;
    in_valid = 1;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 200) begin
        check("accept_timeout", 0, 1);
        done = 1;
      end
    end
    in_valid = 0;
    in_sof = 0;
  endtask

  // kind: 0 random, 1 flat 100, 2 vertical step, 3 prev=255 curr=0
  task automatic run_frame(int npix, int mode, bit sof, int kind, bit gaps);
    int m;
    m = (mode == 3) ? 0 : mode;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        case (kind)
          1: begin fc[yy][xx] = 100; fp[yy][xx] = 100; end
          2: begin
            fc[yy][xx] = (xx >= 2) ? 255 : 0;
            fp[yy][xx] = fc[yy][xx];
          end
          3: begin fc[yy][xx] = 0; fp[yy][xx] = 255; end
          default: begin
            fc[yy][xx] = $urandom_range(0, 255);
            fp[yy][xx] = $urandom_range(0, 255);
          end
        endcase
      end
    for (int cy = 1; cy < H - 1; cy++)
      for (int cx = 1; cx < W - 1; cx++)
        if ((cy + 1) * W + cx + 1 < npix) sb.push_back(model(cx, cy, m));
    cfg_mode = 2'(mode);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(fc[i / W][i % W], fp[i / W][i % W], sof && i == 0);
      cfg_mode = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        out_ready = 0;
        stall_cnt--;
      end else begin
        out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("valid_in_reset", int'(out_valid), 0);
    end else begin
      check("in_ready_rule", int'(in_ready),
            int'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          n_assert++;
          if (out_x != XW'(e.x) || out_y != YW'(e.y) ||
              int'(grad_x) != e.gx || int'(grad_y) != e.gy ||
              int'(grad_t) != e.gt) begin
            n_fail++;
            $display("FAIL output: got (%0d,%0d) %0d %0d %0d expected (%0d,%0d) %0d %0d %0d",
                     out_x, out_y, grad_x, grad_y, grad_t,
                     e.x, e.y, e.gx, e.gy, e.gt);
          end
        end
      end
    end
  end

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_grad_x", int'(grad_x), 0);
    check("rst_grad_y", int'(grad_y), 0);
    check("rst_grad_t", int'(grad_t), 0);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_y", int'(out_y), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    check_reset_state();

    run_frame(W * H, 0, 1, 1, 0);
    run_frame(W * H, 0, 1, 2, 0);
    run_frame(W * H, 1, 1, 2, 0);
    run_frame(W * H, 2, 1, 2, 0);
    run_frame(W * H, 0, 1, 3, 0);
    drain();

    fork
      run_frame(W * H, 2, 1, 0, 0);
      begin
        repeat (15) @(posedge clk);
        #1;
        stall_cnt = 10;
      end
    join
    drain();

    bp_en = 1;
    for (int i = 0; i < 8; i++)
      run_frame(W * H, $urandom_range(0, 3), (i % 2) == 0, 0, 1);
    run_frame(3 * W + 3, 1, 1, 0, 1);
    run_frame(W * H, 2, 1, 0, 1);
    drain();

    run_frame(12, 0, 1, 0, 0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    check_reset_state();
    run_frame(W * H, 3, 0, 0, 1);
    drain();
    bp_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
